// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the store write buffer: funct3 store sizes, strobe width
// and the per-entry lane layout (the word address is held alongside in the top).
package store_write_buffer_pkg;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    localparam int STRB_W = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } swb_lane_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane alignment of right-justified store data into a 32-bit
// memory word, with byte strobes and a flag for misaligned or unknown sizes.
module store_lane_align
    import store_write_buffer_pkg::*;
(
    input  logic [2:0]        size,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              illegal
);

    always_comb begin
        wdata   = data;
        wstrb   = '0;
        illegal = 1'b0;
        case (size)
            SIZE_B: begin
                wdata = {4{data[7:0]}};
                wstrb = 4'b0001 << off;
            end
            SIZE_H: begin
                wdata   = {2{data[15:0]}};
                wstrb   = 4'b0011 << off;
                illegal = off[0];
            end
            SIZE_W: begin
                wstrb   = 4'b1111;
                illegal = (off != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns core stores to byte lanes and queues them in a FIFO
// feeding a valid/ready memory write port. STORE_WRITE_BUFFER_FWD_HAZARD_EN adds
// a load-address hazard check against all pending entries.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              swb_clk,
    input  logic              swb_rst,
    input  logic              swb_in_valid,
    output logic              swb_in_ready,
    input  logic [ADDR_W-1:0] swb_in_addr,
    input  logic [DATA_W-1:0] swb_in_data,
    input  logic [2:0]        swb_in_size,
    output logic              swb_err,
    output logic              swb_mem_valid,
    input  logic              swb_mem_ready,
    output logic [ADDR_W-1:0] swb_mem_addr,
    output logic [DATA_W-1:0] swb_mem_wdata,
    output logic [STRB_W-1:0] swb_mem_wstrb,
    output logic              swb_empty
`ifdef STORE_WRITE_BUFFER_FWD_HAZARD_EN
    ,
    input  logic [ADDR_W-1:0] swb_ld_addr,
    output logic              swb_ld_hazard
`endif
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              err_p1;

    logic [ADDR_W-3:0] word_mem [DEPTH];
    swb_lane_t         lane_mem [DEPTH];

    swb_lane_t         lane_p0;
    logic              illegal_p0;
    logic              offer;
    logic              push;
    logic              pop;

    store_lane_align u_align (
        .size    (swb_in_size),
        .off     (swb_in_addr[1:0]),
        .data    (swb_in_data),
        .wdata   (lane_p0.wdata),
        .wstrb   (lane_p0.wstrb),
        .illegal (illegal_p0)
    );

    // in_ready depends only on registered count, never on mem_ready
    assign swb_in_ready  = (count != CNT_FULL);
    assign swb_mem_valid = (count != '0);
    assign swb_empty     = (count == '0);
    assign swb_err       = err_p1;

    assign offer = swb_in_valid && swb_in_ready;
    assign push  = offer && !illegal_p0;
    assign pop   = swb_mem_valid && swb_mem_ready;

    assign swb_mem_addr  = {word_mem[rd_ptr], 2'b00};
    assign swb_mem_wdata = lane_mem[rd_ptr].wdata;
    assign swb_mem_wstrb = lane_mem[rd_ptr].wstrb;

    // ---- stage p0 -> p1: FIFO control and error pulse ----
    always_ff @(posedge swb_clk) begin
        if (swb_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= offer && illegal_p0;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    // Storage is data only; stale slots are never visible because count gates them.
    always_ff @(posedge swb_clk) begin
        if (push) begin
            word_mem[wr_ptr] <= swb_in_addr[ADDR_W-1:2];
            lane_mem[wr_ptr] <= lane_p0;
        end
    end

`ifdef STORE_WRITE_BUFFER_FWD_HAZARD_EN
    logic unused_ld_off;
    assign unused_ld_off = ^swb_ld_addr[1:0];

    // Scan occupied slots from the head; a popping head entry still matches.
    always_comb begin
        swb_ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PTR_W+1)'(i) < count) &&
                (word_mem[rd_ptr + PTR_W'(i)] == swb_ld_addr[ADDR_W-1:2]))
                swb_ld_hazard = 1'b1;
        end
    end
`endif

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Write-direction counterpart of the load-side memory data register: takes store requests from the core's memory stage and drives the data-memory write port.
- Aligns store data to byte lanes, generates byte strobes and queues stores in a small FIFO, so the core does not stall on a slow memory write.
- Memory side uses a valid/ready handshake.
- Provides an empty flag for fence/halt logic.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- ADDR_W, 32, byte-address width.

Ports:
- swb_clk  input  1  clock; all state changes on rising edge.
- swb_rst  input  1  synchronous, active-high reset.
- swb_in_valid  input  1  core presents a store.
- swb_in_ready  output  1  buffer can accept a store (not full).
- swb_in_addr  input  ADDR_W  byte address of the store.
- swb_in_data  input  32  store data, right-justified (rs2).
- swb_in_size  input  3  funct3: 000 SB, 001 SH, 010 SW.
- swb_err  output  1  one-cycle pulse: the last offered store was misaligned or had an illegal size.
- swb_mem_valid  output  1  head entry present.
- swb_mem_ready  input  1  memory accepts the head entry.
- swb_mem_addr  output  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- swb_mem_wdata  output  32  lane-replicated data.
- swb_mem_wstrb  output  4  byte enables.
- swb_empty  output  1  no pending stores.

Behaviour:
- Reset values:
  - swb_mem_valid=0, swb_err=0, swb_empty=1, swb_in_ready=1.
  - Read/write pointers and count are cleared to 0.
  - Storage array is not cleared.
  - Reset mid-operation discards all pending stores; any handshake in that cycle is ignored.
- swb_in_ready = (count != DEPTH). Purely from registered state; no combinational path from swb_mem_ready.
- Accept:
  - A store is accepted when swb_in_valid && swb_in_ready && legal.
  - The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Lane alignment (off = addr[1:0]):
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << off.
  - SH: wdata = {2{data[15:0]}}, wstrb = 4'b0011 << off.
  - SW: wdata = data, wstrb = 4'b1111.
- Illegal store:
  - Conditions: SH with off[0]=1; SW with off!=0; size not in {000,001,010}.
  - If offered with in_valid && in_ready, the store is dropped (not enqueued) and swb_err=1 in the following cycle only.
- Memory side:
  - swb_mem_valid = (count != 0); mem_addr, mem_wdata and mem_wstrb come from the head entry.
  - Pop on swb_mem_valid && swb_mem_ready; rd_ptr increments modulo DEPTH.
  - Head outputs hold stable while valid && !ready.
- Latency: a store accepted into an empty buffer appears on the memory port the next cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: in_ready=0; a pop in the same cycle does not allow a push in that cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- swb_empty = (count == 0).
- Ordering: strictly FIFO; stores are never merged.

Optional Feature:
- Macro: STORE_WRITE_BUFFER_FWD_HAZARD_EN.
- Adds input swb_ld_addr (ADDR_W) and output swb_ld_hazard (1).
- With the macro:
  - swb_ld_hazard = 1 combinationally when any valid entry's word address equals swb_ld_addr[ADDR_W-1:2].
  - The core stalls the load until the hazard clears.
  - An entry popping in the current cycle still counts as a match.
- Without the macro: the ports are absent. The core must drain (swb_empty=1) before loads.

Decomposition:
- Shared package:
  - funct3 store-size constants (SIZE_B=3'b000, SIZE_H=3'b001, SIZE_W=3'b010).
  - Strobe width constant STRB_W=4.
  - Entry struct/layout: addr word, wdata, wstrb.
- One sub-module, store_lane_align: combinational; takes size, off and data; returns wdata, wstrb and illegal.
- The FIFO and control stay in the top.

Test Plan:
- Reset then SB addr=0x1003 data=0x000000AB, mem_ready=1 -> next cycle mem_valid=1, addr=0x1000, wdata=0xABABABAB, wstrb=4'b1000; empty returns to 1 after the pop.
- SH addr=0x2002 data=0x1234CDEF -> wdata=0xCDEFCDEF, wstrb=4'b1100; SW addr=0x2004 data=0xDEADBEEF -> wstrb=4'b1111, in that order.
- SW addr=0x3001 -> no enqueue, swb_err=1 for exactly one cycle; size=3'b011 -> same.
- mem_ready=0, push 4 SWs -> in_ready=0 after the 4th; a 5th stays offered until mem_ready=1, then entries drain in order 1..5 with no loss or duplication.
- Continuous push/pop with mem_ready=1 for 20 stores -> count never exceeds 1 and pointers wrap correctly; swb_rst asserted with 3 pending -> mem_valid=0 and empty=1 next cycle.
- With STORE_WRITE_BUFFER_FWD_HAZARD_EN: pending SW at 0x4000, ld_addr=0x4002 -> hazard=1; ld_addr=0x4004 -> hazard=0.
